// File: rtl/riscv_defines.sv
// Shared TPR definitions: field layout, mode encodings, op/state enums and the raw-update helper.
// Bit 31 (LOCK) is only meaningful when TPR_LOCK_EN is defined.
package riscv_defines;

  localparam int ALU_MODE_WIDTH = 2;

  localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_OLD  = 2'b00;
  localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_NEW  = 2'b01;
  localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_MIX  = 2'b10;
  localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_RSVD = 2'b11;

  localparam int LOGICAL_LOW     = 0;
  localparam int LOGICAL_HIGH    = 1;
  localparam int COMPARISON_LOW  = 2;
  localparam int COMPARISON_HIGH = 3;
  localparam int SHIFT_LOW       = 4;
  localparam int SHIFT_HIGH      = 5;
  localparam int INTEGER_LOW     = 6;
  localparam int INTEGER_HIGH    = 7;
  localparam int LOADSTORE_LOW   = 8;
  localparam int LOADSTORE_HIGH  = 9;
  localparam int BRANCH_LOW      = 10;
  localparam int BRANCH_HIGH     = 11;
  localparam int JUMP_LOW        = 12;
  localparam int JUMP_HIGH       = 13;
  localparam int TPR_LOCK_BIT    = 31;

  typedef enum logic [1:0] {
    TPR_OP_WRITE = 2'b00,
    TPR_OP_SET   = 2'b01,
    TPR_OP_CLEAR = 2'b10,
    TPR_OP_NONE  = 2'b11
  } tpr_op_e;

  typedef enum logic [1:0] {
    TPR_IDLE   = 2'b00,
    TPR_DRAIN  = 2'b01,
    TPR_COMMIT = 2'b10
  } tpr_state_e;

  // Unlegalized result of a CSR op against the committed value.
  function automatic logic [31:0] tpr_raw(input tpr_op_e op, input logic [31:0] cur,
                                          input logic [31:0] wdata);
    case (op)
      TPR_OP_WRITE: tpr_raw = wdata;
      TPR_OP_SET:   tpr_raw = cur | wdata;
      TPR_OP_CLEAR: tpr_raw = cur & ~wdata;
      default:      tpr_raw = cur;
    endcase
  endfunction

  // A reserved mode encoding keeps the field at its committed value.
  function automatic logic [ALU_MODE_WIDTH-1:0] tpr_field_pick(
      input logic [ALU_MODE_WIDTH-1:0] raw, input logic [ALU_MODE_WIDTH-1:0] cur);
    tpr_field_pick = (raw == ALU_MODE_RSVD) ? cur : raw;
  endfunction

endpackage

// File: rtl/riscv_tpr_writer_if.sv
// CSR request/grant handshake into the TPR writer; master is the CSR requester.
interface riscv_tpr_writer_if;
  import riscv_defines::*;

  logic        csr_req_i;
  logic        csr_gnt_o;
  tpr_op_e     csr_op_i;
  logic [31:0] csr_wdata_i;

  modport master (output csr_req_i, output csr_op_i, output csr_wdata_i, input csr_gnt_o);
  modport slave  (input csr_req_i, input csr_op_i, input csr_wdata_i, output csr_gnt_o);

endinterface

// File: rtl/riscv_tpr_legalize.sv
// Combinational WARL filter from a raw TPR value to the legal value, given the committed value.
// LOCK (bit 31) passes through only when TPR_LOCK_EN is defined.
module riscv_tpr_legalize
  import riscv_defines::*;
(
  input  logic [31:0] raw,
  input  logic [31:0] cur,
  output logic [31:0] legal
);

  always_comb begin
    legal = '0;
    legal[LOGICAL_HIGH:LOGICAL_LOW] =
      tpr_field_pick(raw[LOGICAL_HIGH:LOGICAL_LOW], cur[LOGICAL_HIGH:LOGICAL_LOW]);
    legal[COMPARISON_HIGH:COMPARISON_LOW] =
      tpr_field_pick(raw[COMPARISON_HIGH:COMPARISON_LOW], cur[COMPARISON_HIGH:COMPARISON_LOW]);
    legal[SHIFT_HIGH:SHIFT_LOW] =
      tpr_field_pick(raw[SHIFT_HIGH:SHIFT_LOW], cur[SHIFT_HIGH:SHIFT_LOW]);
    legal[INTEGER_HIGH:INTEGER_LOW] =
      tpr_field_pick(raw[INTEGER_HIGH:INTEGER_LOW], cur[INTEGER_HIGH:INTEGER_LOW]);
    legal[LOADSTORE_HIGH:LOADSTORE_LOW] =
      tpr_field_pick(raw[LOADSTORE_HIGH:LOADSTORE_LOW], cur[LOADSTORE_HIGH:LOADSTORE_LOW]);
    legal[BRANCH_HIGH:BRANCH_LOW] =
      tpr_field_pick(raw[BRANCH_HIGH:BRANCH_LOW], cur[BRANCH_HIGH:BRANCH_LOW]);
    legal[JUMP_HIGH:JUMP_LOW] =
      tpr_field_pick(raw[JUMP_HIGH:JUMP_LOW], cur[JUMP_HIGH:JUMP_LOW]);
`ifdef TPR_LOCK_EN
    legal[TPR_LOCK_BIT] = raw[TPR_LOCK_BIT];
`endif
  end

  // Reserved raw/current bits are dropped on purpose.
  logic unused_rsvd;
`ifdef TPR_LOCK_EN
  assign unused_rsvd = ^{raw[30:14], cur[31:14]};
`else
  assign unused_rsvd = ^{raw[31:14], cur[31:14]};
`endif

endmodule

// File: rtl/riscv_tpr_writer.sv
// TPR write side: grants CSR updates, drains EX, then commits the legalized value to tpr_o.
// Optional TPR_LOCK_EN: bit 31 locks the TPR until reset.
//
// state      | meaning
// TPR_IDLE   | accepting requests; grant follows csr_req_i
// TPR_DRAIN  | update pending, ID stalled, waiting for EX to go idle
// TPR_COMMIT | pending value written to tpr_o, commit_o pulsed
module riscv_tpr_writer
  import riscv_defines::*;
#(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
  parameter int          DRAIN_MAX   = 15
) (
  input  logic               clk,
  input  logic               rst,
  riscv_tpr_writer_if.slave  csr,
  input  logic               ex_busy_i,
  output logic               stall_id_o,
  output logic               commit_o,
  output logic               drain_timeout_o,
  output logic [31:0]        tpr_o
);

  localparam int               CNT_W   = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_MAX);

  tpr_state_e       state;
  logic [31:0]      pending;
  logic [31:0]      raw;
  logic [31:0]      legal;
  logic [CNT_W-1:0] drain_cnt;
  logic             locked;
  logic             accept;

  assign raw = tpr_raw(csr.csr_op_i, tpr_o, csr.csr_wdata_i);

  riscv_tpr_legalize u_legalize (
    .raw   (raw),
    .cur   (tpr_o),
    .legal (legal)
  );

`ifdef TPR_LOCK_EN
  assign locked = tpr_o[TPR_LOCK_BIT];
`else
  assign locked = 1'b0;
`endif

  assign csr.csr_gnt_o = csr.csr_req_i && (state == TPR_IDLE) && !rst;
  // Op 11 and locked requests are granted but never leave IDLE.
  assign accept = csr.csr_gnt_o && (csr.csr_op_i != TPR_OP_NONE) && !locked;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= TPR_IDLE;
      tpr_o           <= RESET_VALUE;
      pending         <= RESET_VALUE;
      drain_cnt       <= '0;
      stall_id_o      <= 1'b0;
      commit_o        <= 1'b0;
      drain_timeout_o <= 1'b0;
    end else begin
      case (state)
        TPR_IDLE: begin
          commit_o <= 1'b0;
          if (accept) begin
            pending    <= legal;
            drain_cnt  <= '0;
            stall_id_o <= 1'b1;
            state      <= TPR_DRAIN;
          end
        end
        TPR_DRAIN: begin
          if (drain_cnt != CNT_MAX) begin
            drain_cnt <= drain_cnt + 1'b1;
          end
          if (!ex_busy_i) begin
            commit_o <= 1'b1;
            state    <= TPR_COMMIT;
          end else if (drain_cnt == CNT_MAX - 1'b1) begin
            drain_timeout_o <= 1'b1;
          end
        end
        TPR_COMMIT: begin
          tpr_o           <= pending;
          commit_o        <= 1'b0;
          stall_id_o      <= 1'b0;
          drain_cnt       <= '0;
          drain_timeout_o <= 1'b0;
          state           <= TPR_IDLE;
        end
        default: begin
          commit_o   <= 1'b0;
          stall_id_o <= 1'b0;
          state      <= TPR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_tpr_writer.sv
// Scoreboard bench for riscv_tpr_writer: driver pushes reference commits, monitor checks tpr_o.
// Exercises TPR_LOCK_EN behaviour when that macro is defined.
module tb_riscv_tpr_writer;
  import riscv_defines::*;

  localparam int DRAIN_MAX = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_busy = 1'b0;
  logic        stall_id, commit, drain_timeout;
  logic [31:0] tpr;

  riscv_tpr_writer_if bus ();

  riscv_tpr_writer #(.RESET_VALUE(32'h0000_0000), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk             (clk),
    .rst             (rst),
    .csr             (bus),
    .ex_busy_i       (ex_busy),
    .stall_id_o      (stall_id),
    .commit_o        (commit),
    .drain_timeout_o (drain_timeout),
    .tpr_o           (tpr)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_tpr = 32'h0;
  logic        prev_commit = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: apply op, then keep any field whose new mode would be 3.
  function automatic logic [31:0] model_commit(input logic [1:0] op, input logic [31:0] cur,
                                               input logic [31:0] wd);
    logic [31:0] r, res;
    int fld;
    case (op)
      2'd0:    r = wd;
      2'd1:    r = cur | wd;
      2'd2:    r = cur & ~wd;
      default: r = cur;
    endcase
    res = 32'h0;
    for (int f = 0; f < 7; f++) begin
      fld = int'((r >> (2 * f)) & 32'h3);
      if (fld == 3) fld = int'((cur >> (2 * f)) & 32'h3);
      res = res | (32'(fld) << (2 * f));
    end
`ifdef TPR_LOCK_EN
    res[31] = r[31];
`endif
    return res;
  endfunction

  function automatic bit model_locked();
`ifdef TPR_LOCK_EN
    return model_tpr[31];
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: the cycle after each commit pulse, tpr_o must equal the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      prev_commit = 1'b0;
    end else begin
      if (prev_commit) begin
        if (exp_q.size() == 0) check("unexpected_commit", tpr, 32'hxxxx_xxxx);
        else check("sb_tpr", tpr, exp_q.pop_front());
      end
      prev_commit = commit;
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [31:0] wd, input int busy);
    bit got, eff;
    logic [31:0] e;
    @(posedge clk); #1;
    bus.csr_req_i   = 1'b1;
    bus.csr_op_i    = tpr_op_e'(op);
    bus.csr_wdata_i = wd;
    ex_busy         = (busy > 0);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.csr_gnt_o) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!got) begin
      check("grant_timeout", {31'b0, got}, 32'h1);
      bus.csr_req_i = 1'b0;
      return;
    end
    check("stall_at_grant", {31'b0, stall_id}, 32'h0);
    eff = (op != 2'b11) && !model_locked();
    if (eff) begin
      e = model_commit(op, model_tpr, wd);
      exp_q.push_back(e);
      model_tpr = e;
    end
    @(posedge clk); #1;
    bus.csr_req_i   = 1'b0;
    bus.csr_op_i    = tpr_op_e'($urandom_range(0, 3));
    bus.csr_wdata_i = $urandom;
    if (!eff) begin
      ex_busy = 1'b0;
      @(negedge clk);
      check("noeff_stall", {31'b0, stall_id}, 32'h0);
      check("noeff_commit", {31'b0, commit}, 32'h0);
      return;
    end
    for (int i = 0; i <= busy; i++) begin
      @(negedge clk);
      check("drain_stall", {31'b0, stall_id}, 32'h1);
      check("drain_commit", {31'b0, commit}, 32'h0);
      check("drain_timeout", {31'b0, drain_timeout}, {31'b0, i >= DRAIN_MAX});
      @(posedge clk); #1;
      if (i == busy - 1) ex_busy = 1'b0;
    end
    @(negedge clk);
    check("commit_pulse", {31'b0, commit}, 32'h1);
    check("commit_stall", {31'b0, stall_id}, 32'h1);
    @(negedge clk);
    check("post_stall", {31'b0, stall_id}, 32'h0);
    check("post_commit", {31'b0, commit}, 32'h0);
    check("post_timeout", {31'b0, drain_timeout}, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.csr_req_i = 1'b0;
    ex_busy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    model_tpr = 32'h0;
  endtask

  initial begin
    bus.csr_req_i   = 1'b0;
    bus.csr_op_i    = TPR_OP_WRITE;
    bus.csr_wdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1 bus.csr_req_i = 1'b1;
    @(negedge clk);
    check("gnt_in_reset", {31'b0, bus.csr_gnt_o}, 32'h0);
    do_reset();
    @(negedge clk);
    check("reset_tpr", tpr, 32'h0);
    check("reset_stall", {31'b0, stall_id}, 32'h0);
    check("reset_commit", {31'b0, commit}, 32'h0);
    check("reset_timeout", {31'b0, drain_timeout}, 32'h0);

    do_req(2'd0, 32'h0000_1555, 0);
    check("write_1555", tpr, 32'h0000_1555);
    do_req(2'd0, 32'h0000_000F, 0);
    check("warl_keep", tpr, 32'h0000_0005);
    do_req(2'd1, 32'h0000_0020, 1);
    check("set_20", tpr, 32'h0000_0025);
    do_req(2'd2, 32'h0000_0001, 2);
    check("clear_1", tpr, 32'h0000_0024);
    do_req(2'd3, 32'hFFFF_FFFF, 0);
    check("op11_nochange", tpr, 32'h0000_0024);
    do_req(2'd0, 32'h0000_0024, 0);
    do_req(2'd0, 32'h0000_2AAA, 20);

    // Back-to-back: second request held through DRAIN/COMMIT of the first.
    @(posedge clk); #1;
    bus.csr_req_i = 1'b1; bus.csr_op_i = TPR_OP_WRITE; bus.csr_wdata_i = 32'h0000_1111;
    @(negedge clk);
    check("b2b_gnt0", {31'b0, bus.csr_gnt_o}, 32'h1);
    model_tpr = model_commit(2'd0, model_tpr, 32'h0000_1111);
    exp_q.push_back(model_tpr);
    @(posedge clk); #1;
    bus.csr_op_i = TPR_OP_SET; bus.csr_wdata_i = 32'h0000_0900;
    @(negedge clk);
    check("b2b_gnt_drain", {31'b0, bus.csr_gnt_o}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_gnt_commit", {31'b0, bus.csr_gnt_o}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_gnt_next", {31'b0, bus.csr_gnt_o}, 32'h1);
    model_tpr = model_commit(2'd1, model_tpr, 32'h0000_0900);
    exp_q.push_back(model_tpr);
    @(posedge clk); #1;
    bus.csr_req_i = 1'b0; bus.csr_op_i = TPR_OP_WRITE; bus.csr_wdata_i = 32'hFFFF_FFFF;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("b2b_final", tpr, 32'h0000_1911);

    // Reset while a WRITE is draining discards it.
    @(posedge clk); #1;
    ex_busy = 1'b1;
    bus.csr_req_i = 1'b1; bus.csr_op_i = TPR_OP_WRITE; bus.csr_wdata_i = 32'h0000_3FFE;
    @(posedge clk); #1;
    bus.csr_req_i = 1'b0;
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("rst_drain_tpr", tpr, 32'h0);
    check("rst_drain_stall", {31'b0, stall_id}, 32'h0);
    check("rst_drain_commit", {31'b0, commit}, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_drain_stays", tpr, 32'h0);

    for (int k = 0; k < 30; k++) begin
      logic [31:0] wd;
      wd = (k % 3 == 0) ? $urandom : ($urandom & 32'h0000_3FFF);
`ifdef TPR_LOCK_EN
      wd[31] = 1'b0;
`endif
      do_req(2'($urandom_range(0, 3)), wd, (k % 7 == 6) ? 17 : int'($urandom_range(0, 3)));
    end

`ifdef TPR_LOCK_EN
    do_reset();
    do_req(2'd0, 32'h8000_0001, 0);
    check("lock_set", tpr, 32'h8000_0001);
    do_req(2'd0, 32'h0000_0000, 0);
    do_req(2'd2, 32'h8000_0000, 0);
    check("lock_hold", tpr, 32'h8000_0001);
    do_reset();
    @(negedge clk);
    check("lock_rst", tpr, 32'h0);
    do_req(2'd0, 32'h0000_0015, 0);
    check("unlock_write", tpr, 32'h0000_0015);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_tpr_writer.md
# riscv_tpr_writer

Write side of the Tag Propagation Register (TPR). Owns the architectural TPR in the CSR block. Accepts CSR write/set/clear requests and legalizes each per-class mode field. Commits the new value only after the EX stage has drained, so no in-flight instruction is decoded by the mode-tag decoder with a half-changed policy. `tpr_o` is the single source feeding the ID-stage mode decoder.

## Interface
Parameters:
- `RESET_VALUE`, 32'h0000_0000: TPR value after reset; all fields `ALU_MODE_OLD`.
- `DRAIN_MAX`, 15: DRAIN cycles before `drain_timeout_o` asserts.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  synchronous reset, active high.
- `csr_req_i`  in  1  TPR write request.
- `csr_gnt_o`  out  1  request accepted this cycle.
- `csr_op_i`  in  2  `TPR_OP_WRITE`=00, `TPR_OP_SET`=01, `TPR_OP_CLEAR`=10; 11 ignored (granted, no change).
- `csr_wdata_i`  in  32  operand.
- `ex_busy_i`  in  1  EX holds an instruction using the current mode.
- `stall_id_o`  out  1  hold ID/IF while an update is pending.
- `commit_o`  out  1  one-cycle pulse when `tpr_o` changes.
- `drain_timeout_o`  out  1  sticky; DRAIN exceeded `DRAIN_MAX`; cleared by next commit.
- `tpr_o`  out  32  committed TPR, also the CSR read value.

## Operation
- Layout is in the package. Seven 2-bit fields (`ALU_MODE_WIDTH`=2):
  - LOGICAL [1:0], COMPARISON [3:2], SHIFT [5:4], INTEGER [7:6], LOADSTORE [9:8], BRANCH [11:10], JUMP [13:12].
  - Bits [30:14] are reserved and read zero.
  - Bit [31] is LOCK, present only with the macro; otherwise it reads zero.
- Raw result:
  - WRITE: `wdata`.
  - SET: `tpr | wdata`.
  - CLEAR: `tpr & ~wdata`.
- Legalization (WARL), per field: raw value 2'b11 (reserved mode) leaves that field at its current committed value. Reserved bits are forced to 0.
- FSM states:
  - IDLE: `csr_gnt_o = csr_req_i`. On grant, latch the legalized value into `pending` and go to DRAIN. Op 11 is granted and stays in IDLE.
  - DRAIN: `stall_id_o=1`. The drain counter increments and saturates at `DRAIN_MAX`. When `ex_busy_i==0`, go to COMMIT. When the counter reaches `DRAIN_MAX`, set `drain_timeout_o`; keep waiting.
  - COMMIT: `stall_id_o=1`. `tpr_o <= pending`, `commit_o=1`, counter cleared, `drain_timeout_o` cleared, go to IDLE.
- `csr_gnt_o=0` in DRAIN and COMMIT. The requester holds `csr_req_i`, `csr_op_i` and `csr_wdata_i` stable until granted.
- Operands are sampled only at grant. Later changes to `csr_wdata_i` have no effect.
- A commit whose value equals the current TPR still pulses `commit_o`.

## Timing
- Grant in IDLE is combinational, same cycle as the request.
- Minimum latency: grant in cycle N, DRAIN in N+1 with `ex_busy_i=0`, COMMIT in N+2. New `tpr_o` is visible from N+3.
- `stall_id_o` is high in cycles N+1..N+2. It is registered from the state, with no combinational path from inputs.
- Each extra cycle of `ex_busy_i=1` in DRAIN adds one cycle.
- Back-to-back requests: the earliest next grant is the cycle after COMMIT. Updates never merge.
- Reset, including mid-DRAIN or mid-COMMIT:
  - next state IDLE;
  - `tpr_o=RESET_VALUE`, `pending=RESET_VALUE`;
  - `stall_id_o=0`, `commit_o=0`, `csr_gnt_o=0`, `drain_timeout_o=0`, counter 0.
- A pending value is discarded on reset.

## Configuration
- `TPR_LOCK_EN` defined:
  - Bit 31 is LOCK. Once a commit sets it, every later request is still granted but ends in IDLE with no DRAIN, no stall and no change.
  - LOCK clears only on `rst`.
  - CLEAR cannot unlock.
- `TPR_LOCK_EN` undefined: bit 31 is reserved (forced 0) and writes are always effective.

## Structure
- Shared package `riscv_defines`:
  - `ALU_MODE_WIDTH` and the mode encodings;
  - `*_HIGH`/`*_LOW` field bounds and `TPR_LOCK_BIT`;
  - the `tpr_op_e` enum and the `tpr_state_e` enum (IDLE/DRAIN/COMMIT).
- Sub-module `riscv_tpr_legalize`: combinational raw-to-legal field filter, reused by the CSR read/debug path.

## Test plan
- Reset, then WRITE 32'h0000_1555 with `ex_busy_i=0`: grant at N, `stall_id_o` high N+1..N+2, `commit_o` pulse at N+2, `tpr_o=32'h0000_1555` from N+3.
- Starting from 32'h0000_1555, WRITE 32'h0000_000F: LOGICAL field value 11 is kept as 01, COMPARISON becomes 11→kept 01, so `tpr_o=32'h0000_0005`. Then SET 32'h0000_0020 → 32'h0000_0025. Then CLEAR 32'h0000_0001 → 32'h0000_0024.
- Hold `ex_busy_i=1` for 20 cycles after grant with `DRAIN_MAX`=15: `drain_timeout_o` rises and stays high with stall held. Drop `ex_busy_i`: commit occurs and `drain_timeout_o` clears.
- Second request held high during DRAIN: `csr_gnt_o` stays 0 until the cycle after COMMIT. Operand changes before grant are honoured; those after grant are ignored.
- Assert `rst` during DRAIN with a pending WRITE 32'h0000_3FFE: next cycle IDLE, `tpr_o=RESET_VALUE`, no `commit_o`.
- With `TPR_LOCK_EN`: WRITE 32'h8000_0001 commits. A following WRITE 32'h0000_0000 is granted with no stall and `tpr_o` stays 32'h8000_0001 until `rst`.
